// File: rtl/traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// traffic_phase_scheduler
//
// Demand-driven phase scheduler for the highway / country-road intersection.
// The highway rests on green. A country-road vehicle (car_sense) or a latched
// pedestrian request (ped_pending) pre-empts it once the highway minimum green
// has elapsed. Pedestrians are served before the country green.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; returns to HWY_GREEN immediately
//   car_sense    country-road vehicle present (level, synchronous)
//   ped_btn      pedestrian button (synchronous, any pulse width)
//   lightA[2:0]  country lamps  (001 green, 010 yellow, 100 red)
//   lightB[2:0]  highway lamps  (same encoding)
//   walk         pedestrian WALK lamp
//   ped_pending  latched pedestrian request awaiting service
//   phase[2:0]   current state code (debug)
//
// There are no handshakes. Inputs are sampled on every rising edge. All outputs
// decode from registers only, so an input change reaches a lamp one edge later.
// -----------------------------------------------------------------------------
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALL_RED_T = 1,
  parameter int WALK_T    = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_sense,
  input  logic       ped_btn,
  output logic [2:0] lightA,
  output logic [2:0] lightB,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    HWY_GREEN   = 3'd0,
    HWY_YELLOW  = 3'd1,
    RED_1       = 3'd2,
    WALK        = 3'd3,
    CTRY_GREEN  = 3'd4,
    CTRY_YELLOW = 3'd5,
    RED_2       = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  // Terminal counts: a phase of n cycles ends when count == n-1.
  localparam logic [CNT_W-1:0] MIN_G_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_G_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] RED_M1   = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] WALK_M1  = CNT_W'(WALK_T - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             ped_next;

  // ---------------------------------------------------------------------------
  // State, timer and pedestrian latch registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HWY_GREEN;
      count       <= '0;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      ped_pending <= ped_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, timer and request-latch logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    count_next = count + CNT_W'(1);
    ped_next   = ped_pending;

    case (state)
      HWY_GREEN: begin
        if (count == MIN_G_M1 && (car_sense || ped_pending))
          state_next = HWY_YELLOW;
      end
      HWY_YELLOW: if (count == YEL_M1) state_next = RED_1;
      RED_1: begin
        if (count == RED_M1)
          state_next = ped_pending ? WALK : CTRY_GREEN;
      end
      WALK: begin
        if (count == WALK_M1)
          state_next = car_sense ? CTRY_GREEN : HWY_GREEN;
      end
      CTRY_GREEN: begin
        // Gap-out once minimum green is served, or max-out unconditionally.
        if ((count >= MIN_G_M1 && !car_sense) || count == MAX_G_M1)
          state_next = CTRY_YELLOW;
      end
      CTRY_YELLOW: if (count == YEL_M1) state_next = RED_2;
      RED_2:       if (count == RED_M1) state_next = HWY_GREEN;
      default:     state_next = HWY_GREEN;
    endcase

    // Timer clears on every state entry; highway green saturates so the
    // pre-emption check stays armed indefinitely.
    if (state_next != state)
      count_next = '0;
    else if (state == HWY_GREEN && count == MIN_G_M1)
      count_next = count;

    // Entering WALK services the request and beats a simultaneous press;
    // presses during WALK are dropped because the walker is already served.
    if (state_next == WALK && state != WALK)
      ped_next = 1'b0;
    else if (ped_btn && state != WALK)
      ped_next = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Output decode from the state register only
  // ---------------------------------------------------------------------------
  always_comb begin
    lightA = LAMP_RED;
    lightB = LAMP_RED;
    walk   = 1'b0;
    case (state)
      HWY_GREEN:   lightB = LAMP_GREEN;
      HWY_YELLOW:  lightB = LAMP_YELLOW;
      WALK:        walk   = 1'b1;
      CTRY_GREEN:  lightA = LAMP_GREEN;
      CTRY_YELLOW: lightA = LAMP_YELLOW;
      default: begin
        lightA = LAMP_RED;
        lightB = LAMP_RED;
      end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_scheduler
//
// Directed bench for traffic_phase_scheduler with default timing parameters.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, between edges.
// -----------------------------------------------------------------------------
module tb_traffic_phase_scheduler;

  logic       clk;
  logic       reset;
  logic       car_sense;
  logic       ped_btn;
  logic [2:0] lightA;
  logic [2:0] lightB;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;

  traffic_phase_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .car_sense  (car_sense),
    .ped_btn    (ped_btn),
    .lightA     (lightA),
    .lightB     (lightB),
    .walk       (walk),
    .ped_pending(ped_pending),
    .phase      (phase)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lamp values for each phase code, straight from the phase table.
  function automatic logic [2:0] exp_a(input logic [2:0] ph);
    case (ph)
      3'd4:    return 3'b001;
      3'd5:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_b(input logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at t=%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all outputs for a phase, then advance one edge; repeat n times.
  task automatic run(input logic [2:0] ph, input int n, input logic pend);
    for (int i = 0; i < n; i++) begin
      chk("phase",       phase,       ph);
      chk("lightA",      lightA,      exp_a(ph));
      chk("lightB",      lightB,      exp_b(ph));
      chk("walk",        walk,        (ph == 3'd3));
      chk("ped_pending", ped_pending, pend);
      tick();
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    car_sense = 1'b0;
    ped_btn   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    car_sense = 1'b0;
    ped_btn   = 1'b0;
    tick();

    // Idle: highway rests on green for 100 cycles.
    do_reset();
    run(3'd0, 100, 1'b0);
    // Minimum service: demand after saturation yields yellow on the next edge.
    car_sense = 1'b1;
    run(3'd0, 1, 1'b0);
    run(3'd1, 1, 1'b0);

    // Continuous car: 5/2/1/10/2/1 then highway green again.
    do_reset();
    car_sense = 1'b1;
    run(3'd0, 5, 1'b0);
    run(3'd1, 2, 1'b0);
    run(3'd2, 1, 1'b0);
    run(3'd4, 10, 1'b0);
    run(3'd5, 2, 1'b0);
    run(3'd6, 1, 1'b0);
    run(3'd0, 5, 1'b0);
    run(3'd1, 1, 1'b0);

    // Gap-out: car leaves 3 cycles into country green; green lasts MIN_GREEN.
    do_reset();
    car_sense = 1'b1;
    run(3'd0, 5, 1'b0);
    run(3'd1, 2, 1'b0);
    run(3'd2, 1, 1'b0);
    run(3'd4, 3, 1'b0);
    car_sense = 1'b0;
    run(3'd4, 2, 1'b0);
    run(3'd5, 2, 1'b0);
    run(3'd6, 1, 1'b0);
    run(3'd0, 8, 1'b0);

    // Pedestrian only: press at cycle 10, WALK served, no country green.
    do_reset();
    run(3'd0, 10, 1'b0);
    ped_btn = 1'b1;
    run(3'd0, 1, 1'b0);
    ped_btn = 1'b0;
    run(3'd0, 1, 1'b1);
    run(3'd1, 2, 1'b1);
    run(3'd2, 1, 1'b1);
    run(3'd3, 4, 1'b0);
    run(3'd0, 8, 1'b0);

    // Ped + car: 0,1,2,3,4,5,6,0; press on WALK entry and during WALK ignored.
    do_reset();
    ped_btn   = 1'b1;
    car_sense = 1'b1;
    run(3'd0, 1, 1'b0);
    ped_btn = 1'b0;
    run(3'd0, 4, 1'b1);
    run(3'd1, 2, 1'b1);
    ped_btn = 1'b1;
    run(3'd2, 1, 1'b1);
    run(3'd3, 1, 1'b0);
    ped_btn = 1'b0;
    run(3'd3, 3, 1'b0);
    run(3'd4, 10, 1'b0);
    run(3'd5, 2, 1'b0);
    run(3'd6, 1, 1'b0);
    run(3'd0, 2, 1'b0);

    // Async reset during country green with a request latched.
    do_reset();
    car_sense = 1'b1;
    run(3'd0, 5, 1'b0);
    run(3'd1, 2, 1'b0);
    run(3'd2, 1, 1'b0);
    ped_btn = 1'b1;
    run(3'd4, 1, 1'b0);
    ped_btn = 1'b0;
    run(3'd4, 2, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_phase",  phase,       3'd0);
    chk("rst_lightA", lightA,      3'b100);
    chk("rst_lightB", lightB,      3'b001);
    chk("rst_walk",   walk,        1'b0);
    chk("rst_ped",    ped_pending, 1'b0);
    tick();
    reset     = 1'b0;
    car_sense = 1'b0;
    // Lost request: no pre-emption after release.
    run(3'd0, 8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-driven phase scheduler for the highway/country-road intersection. It replaces fixed-time cycling with sensor-actuated sequencing. The highway rests on green. A country-road vehicle sensor or a latched pedestrian request pre-empts it, subject to minimum-green, maximum-green, yellow and all-red timing. It drives the two 3-bit lamp buses plus a pedestrian WALK lamp and sits directly above the lamp drivers.

## Interface
- MIN_GREEN, 5, minimum green duration in cycles for either road (≥1)
- MAX_GREEN, 10, maximum country green duration in cycles (≥ MIN_GREEN)
- YELLOW_T, 2, yellow duration in cycles (≥1)
- ALL_RED_T, 1, all-red clearance duration in cycles (≥1)
- WALK_T, 4, pedestrian WALK duration in cycles (≥1)
- CNT_W, 4, phase timer width; must hold max(all durations)−1
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- car_sense  input  1  country-road vehicle present (level, synchronous to clk)
- ped_btn  input  1  pedestrian button (synchronous to clk, any pulse width)
- lightA  output  3  country lamps: 001 green, 010 yellow, 100 red
- lightB  output  3  highway lamps, same encoding
- walk  output  1  pedestrian WALK lamp
- ped_pending  output  1  latched pedestrian request awaiting service
- phase  output  3  current state code (debug)

## Operation
- **States (phase code):**
  - HWY_GREEN 0: A=100, B=001
  - HWY_YELLOW 1: A=100, B=010
  - RED_1 2: A=100, B=100
  - WALK 3: A=100, B=100, walk=1
  - CTRY_GREEN 4: A=001, B=100
  - CTRY_YELLOW 5: A=010, B=100
  - RED_2 6: A=100, B=100
  - walk=0 in every state except WALK.
  - Code 7 is illegal and returns to HWY_GREEN on the next edge.
- **Timer:** count clears to 0 on every state entry and increments once per cycle in the state. "Elapsed n" means count==n−1.
- **HWY_GREEN:**
  - Before MIN_GREEN has elapsed: stay.
  - Once count reaches MIN_GREEN−1, count saturates there.
  - Exit to HWY_YELLOW on the first edge where count==MIN_GREEN−1 and (car_sense | ped_pending).
- **HWY_YELLOW:** after YELLOW_T cycles → RED_1.
- **RED_1:** after ALL_RED_T cycles → WALK if ped_pending, else CTRY_GREEN. Pedestrians take priority.
- **WALK:** after WALK_T cycles → CTRY_GREEN if car_sense, else HWY_GREEN. No extra all-red is needed.
- **CTRY_GREEN:** exit to CTRY_YELLOW on the first edge where either:
  - count ≥ MIN_GREEN−1 and car_sense=0 (gap-out), or
  - count==MAX_GREEN−1 (max-out), regardless of car_sense.
- **CTRY_YELLOW:** after YELLOW_T cycles → RED_2.
- **RED_2:** after ALL_RED_T cycles → HWY_GREEN.
- **ped_pending:**
  - Set on any edge with ped_btn=1.
  - Cleared on the edge that enters WALK; the clear wins over a simultaneous ped_btn.
  - ped_btn while in WALK is ignored.
  - ped_btn in any other state, including CTRY_GREEN, sets it. Service then occurs in the next highway pre-emption.
- **Output decode:** lamp, walk and phase outputs decode only from the state register; there is no combinational path from inputs. Conflicting greens (A and B both 001) are impossible by construction.

## Timing
- **Reset (async assert):** state=HWY_GREEN, count=0, ped_pending=0, lightA=100, lightB=001, walk=0, phase=0, all immediately without waiting for a clock.
- **Reset release:** the first rising edge after deassertion is timer cycle 0 of HWY_GREEN.
- **Latency:** input to lamp change is 1 edge, counted from the edge that samples a qualifying input.
- **Minimum service:** car_sense arriving after HWY_GREEN saturation gives yellow on the next edge.
- **Minimum cycle:** with defaults and permanent demand, the cycle is 5 + 2 + 1 + 10 + 2 + 1 = 21 cycles.
- **Reset mid-phase:** immediate return to the reset state. Any pending pedestrian request is lost.
- **Clock-enable:** none; every edge advances the timer.

## Test plan
- **Idle:** reset, car_sense=0, ped_btn=0 for 100 cycles → lightB=001, lightA=100, walk=0, phase=0 throughout; count holds at 4.
- **Continuous car:** car_sense=1 from reset release → B=001 for 5 cycles, B=010 for 2, all-red 1, A=001 for 10 (max-out), A=010 for 2, all-red 1, then B=001 again (21-cycle period).
- **Gap-out:** car_sense=1 until 3 cycles into CTRY_GREEN, then 0 → CTRY_GREEN lasts exactly 5 cycles (MIN_GREEN), then A=010.
- **Pedestrian:** 1-cycle ped_btn at cycle 10 with car_sense=0 → ped_pending=1 next cycle, B=010 for 2, all-red 1, walk=1 for 4 with ped_pending=0, then back to phase 0 with no country green.
- **Ped + car:** ped_btn pulse and car_sense=1 together → sequence 0,1,2,3 (walk 4 cycles),4,5,6,0. A ped_btn on the WALK-entry edge leaves ped_pending=0.
- **Async reset in CTRY_GREEN with ped_pending=1** → outputs return to A=100, B=001, walk=0, ped_pending=0 before the next clock edge.
